dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the CPU data-memory request interface.
//  It takes read/write requests driven by the EX/MEM stage (address, read/write strobes, store data).
//  It serves them from an internal word array after a fixed number of wait states.
//  It stalls the pipeline while an access is in flight and returns registered read data with a valid pulse.
//  It rejects malformed requests and counts completed accesses for performance tracking.
// PARAMETERS
//  DEPTH    32  number of 32-bit words; power of 2, 2..1024
//  LATENCY   2  stall cycles per access, 1..15
//  CNT_W    16  width of the saturating access counters
// PORTS
//  clk_i        in   1      clock; all state updates on rising edge
//  rst_i        in   1      reset, synchronous, active-high
//  req_addr_i   in   32     byte address (EX/MEM ALU result)
//  req_read_i   in   1      load request (EX/MEM MemRead)
//  req_write_i  in   1      store request (EX/MEM MemWrite)
//  req_wdata_i  in   32     store data (EX/MEM forwarded rs2)
//  stall_o      out  1      freeze PC/IFID/IDEX/EXMEM this cycle
//  rdata_o      out  32     load data, registered
//  rvalid_o     out  1      one-cycle pulse: rdata_o valid for a completed load
//  err_o        out  1      one-cycle pulse: request was rejected
//  rd_count_o   out  CNT_W  completed loads, saturating
//  wr_count_o   out  CNT_W  completed stores, saturating
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge):
//    - state -> IDLE; every array word cleared to 0.
//    - rdata_o, rvalid_o, err_o, rd_count_o and wr_count_o all cleared to 0.
//    - stall_o is forced to 0 while rst_i=1.
//  - FSM states IDLE, BUSY, DONE.
//  - IDLE:
//    - A request exists when req_read_i | req_write_i. It is accepted in cycle T.
//    - stall_o = 1 combinationally during T.
//    - At the edge: state -> BUSY, cnt <= LATENCY-1, and addr/wdata/kind are latched.
//  - BUSY:
//    - stall_o = 1.
//    - If cnt != 0: cnt decrements.
//    - If cnt == 0: the access executes at this edge and state -> DONE.
//    - Store: array[addr[log2(DEPTH)+1:2]] <= wdata.
//    - Load: rdata_o <= array word, rvalid_o <= 1.
//  - DONE:
//    - stall_o = 0; the pipeline advances at the end of this cycle.
//    - Request inputs are ignored; they still show the old request. state -> IDLE.
//    - rvalid_o and err_o clear at the edge leaving DONE.
//  - Timing:
//    - stall_o is high for cycles T..T+LATENCY; result visible in T+LATENCY+1.
//    - Back-to-back accesses cost LATENCY+2 cycles each.
//  - Rejected requests take the same timing but touch no array word and leave rdata_o unchanged.
//    - In DONE: err_o = 1 and rvalid_o = 0. Counters do not change.
//    - Reject causes: req_read_i & req_write_i both set; req_addr_i[1:0] != 0; word index >= DEPTH.
//  - Counters:
//    - +1 per completed load or store, updated at the execute edge.
//    - They hold at 2^CNT_W-1 (no wrap).
//  - Reset mid-access (BUSY): the pending store is discarded (array zeroed anyway).
//    - Next cycle: stall_o = 0 and state is IDLE.
//  - No request in IDLE: stall_o = 0 and state holds.
// TESTING
//  - Reset, then an IDLE cycle with no request -> stall_o=0, rvalid_o=0, counters 0.
//  - Store 0xDEADBEEF to addr 0x10 with LATENCY=2, accepted in T:
//    - stall_o=1 in T..T+2 and 0 in T+3.
//    - wr_count_o=1 from T+3.
//  - Load from 0x10 issued after the store:
//    - rvalid_o=1 and rdata_o=0xDEADBEEF in exactly one cycle.
//    - rd_count_o=1.
//  - Rejected requests: load from 0x13 (misaligned), load from 0x80 with DEPTH=32 (out of range), read+write together.
//    - Each -> err_o pulse, rvalid_o=0, counters unchanged, array intact.
//  - Reset asserted during BUSY of a store to 0x20:
//    - stall_o=0 the next cycle and state is IDLE.
//    - A subsequent load from 0x20 returns 0.
//  - CNT_W=2, five stores -> wr_count_o saturates at 3.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one load/store at a time from a word array after
// a fixed number of wait states, stalling the pipeline and pulsing rvalid/err on completion.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      req_addr_i,
  input  logic             req_read_i,
  input  logic             req_write_i,
  input  logic [31:0]      req_wdata_i,
  output logic             stall_o,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] wr_count_o,
  output logic [1:0]       dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Handshake: a request (read|write) is taken in IDLE; stall_o stays high from the
  // accept cycle through the execute cycle, and the one DONE cycle with stall_o=0
  // lets the pipeline advance while request inputs are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic              is_read_q;
  logic              is_err_q;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;

  logic req;
  logic bad_req;
  logic accept;
  logic exec;
  logic stall;

  assign req     = req_read_i | req_write_i;
  // Any address bit above the word index means the index would exceed DEPTH.
  assign bad_req = (req_read_i & req_write_i) | (req_addr_i[1:0] != 2'b00)
                 | (|req_addr_i[31:AW+2]);
  assign accept  = (state_q == IDLE) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          exec    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_read_q <= 1'b0;
      is_err_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q    <= req_addr_i[AW+1:2];
        wdata_q   <= req_wdata_i;
        is_read_q <= req_read_i;
        is_err_q  <= bad_req;
      end
      if (state_q == DONE) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
      end
      if (exec) begin
        if (is_err_q) begin
          err_q <= 1'b1;
        end else if (is_read_q) begin
          rdata_q  <= mem_q[addr_q];
          rvalid_q <= 1'b1;
          if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
        end else begin
          mem_q[addr_q] <= wdata_q;
          if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
    end
  end

  assign stall_o     = stall & ~rst_i;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a word-array reference model predicts
// each access outcome; a monitor compares whenever the DUT sits in its completion cycle.
module tb_dmem_responder;

  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;
  localparam int AW      = $clog2(DEPTH);
  localparam int EW      = 70;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_wdata;

  logic        stall_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [15:0] rd_count_o, wr_count_o;
  logic [1:0]  dbg_state_o;

  logic        s_stall, s_rvalid, s_err;
  logic [31:0] s_rdata;
  logic [1:0]  s_rd_count, s_wr_count;
  logic [1:0]  s_state;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_read_i(req_read),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .stall_o(stall_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .rd_count_o(rd_count_o), .wr_count_o(wr_count_o), .dbg_state_o(dbg_state_o)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_read_i(req_read),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .stall_o(s_stall),
    .rdata_o(s_rdata), .rvalid_o(s_rvalid), .err_o(s_err),
    .rd_count_o(s_rd_count), .wr_count_o(s_wr_count), .dbg_state_o(s_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // reference model
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  int          m_rd_n;
  int          m_wr_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cap(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rdata = '0;
    m_rd_n  = 0;
    m_wr_n  = 0;
  endtask

  task automatic set_idle();
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Drives one request (called just after a rising edge), predicts its outcome,
  // waits for the completion cycle and leaves the inputs idle after it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic        bad;
    logic        e_rvalid, e_err;
    logic [AW-1:0] idx;
    int          n;
    logic        done;
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    bad = (rd && wr) || (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    idx = addr[AW+1:2];
    e_rvalid = 1'b0;
    e_err    = 1'b0;
    if (bad) begin
      e_err = 1'b1;
    end else if (rd) begin
      m_rdata  = m_mem[idx];
      e_rvalid = 1'b1;
      m_rd_n++;
    end else begin
      m_mem[idx] = wd;
      m_wr_n++;
    end
    exp_q.push_back({e_rvalid, e_err, m_rdata,
                     16'(cap(m_rd_n, 65535)), 16'(cap(m_wr_n, 65535)),
                     2'(cap(m_rd_n, 3)), 2'(cap(m_wr_n, 3))});
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    if (done) begin
      chk("stall_cycles", 32'(n), 32'(LATENCY + 1));
    end else begin
      checks++;
      errors++;
      $display("FAIL stall_timeout actual=stuck expected=release within 20 cycles");
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (dbg_state_o == 2'd2) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid",   {31'd0, rvalid_o}, {31'd0, e[69]});
          chk("err",      {31'd0, err_o},    {31'd0, e[68]});
          chk("rdata",    rdata_o,           e[67:36]);
          chk("rd_count", {16'd0, rd_count_o}, {16'd0, e[35:20]});
          chk("wr_count", {16'd0, wr_count_o}, {16'd0, e[19:4]});
          chk("sat_rd_count", {30'd0, s_rd_count}, {30'd0, e[3:2]});
          chk("sat_wr_count", {30'd0, s_wr_count}, {30'd0, e[1:0]});
        end
      end else if (rvalid_o || err_o) begin
        chk("stray_pulse", {30'd0, rvalid_o, err_o}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int sel, kind, gap;
    logic [31:0] a;
    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall",    {31'd0, stall_o},  32'd0);
    chk("reset_rvalid",   {31'd0, rvalid_o}, 32'd0);
    chk("reset_err",      {31'd0, err_o},    32'd0);
    chk("reset_rdata",    rdata_o,           32'd0);
    chk("reset_rd_count", {16'd0, rd_count_o}, 32'd0);
    chk("reset_wr_count", {16'd0, wr_count_o}, 32'd0);
    chk("reset_state",    {30'd0, dbg_state_o}, 32'd0);
    @(posedge clk);
    #1;

    // directed: store, load back, rejects, array intact
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 1'b0, 32'h13, 32'h0);
    issue(1'b1, 1'b0, 32'h80, 32'h0);
    issue(1'b1, 1'b1, 32'h10, 32'h11111111);
    issue(1'b1, 1'b0, 32'h10, 32'h0);

    // reset while a store to 0x20 is in BUSY
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", {30'd0, dbg_state_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    chk("post_reset_stall", {31'd0, stall_o}, 32'd0);
    chk("post_reset_state", {30'd0, dbg_state_o}, 32'd0);
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h20, 32'h0);

    // five stores drive the 2-bit counters into saturation
    for (int i = 0; i < 5; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
      else if (sel == 1) a = 32'($urandom_range(DEPTH, 1000) * 4);
      else               a = 32'($urandom_range(0, DEPTH - 1) * 4);
      kind = $urandom_range(0, 19);
      if (kind == 0)     issue(1'b1, 1'b1, a, $urandom);
      else if (kind < 10) issue(1'b1, 1'b0, a, $urandom);
      else               issue(1'b0, 1'b1, a, $urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
